// File: rtl/glip_uart_rx_ctrl_if.sv
// glip_uart_rx_ctrl_if
//
// Word stream between the UART receive controller and the 16-bit GLIP FIFO.
// A word is transferred on any clock edge where out_valid and out_ready are both high.
//
// Signals
//   out_data   16  assembled word; the first received byte is in [15:8]
//   out_valid   1  a word is held on out_data
//   out_ready   1  the FIFO accepts the word
//
// Modports
//   master  producer side (the receive controller)
//   slave   consumer side (the FIFO)
interface glip_uart_rx_ctrl_if;

  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/glip_uart_rx_ctrl.sv
// glip_uart_rx_ctrl
//
// Receive-side controller that sits between the UART byte receiver and the
// 16-bit GLIP FIFO. It does the following:
//   - decodes the escape protocol
//   - assembles pairs of data bytes into words
//   - separates out in-band control codes
//   - keeps sticky error flags for framing, overflow and protocol errors
//
// Escape protocol
//   ESC ESC          one literal ESC data byte
//   ESC X (X != ESC) control code X
//
// Ports
//   clk           in    1  clock
//   rst           in    1  synchronous active-high reset
//   in_enable     in    1  one-cycle strobe: valid byte on in_data
//   in_data       in    8  received byte
//   in_error      in    1  one-cycle strobe: framing error (bad stop bit)
//   fifo          master   word stream towards the FIFO (out_data/out_valid/out_ready)
//   ctrl_strobe   out   1  one-cycle pulse: control code decoded
//   ctrl_code     out   8  control code, valid with ctrl_strobe
//   err_framing   out   1  sticky: in_error seen
//   err_overflow  out   1  sticky: word completed while buffer full and not draining
//   err_protocol  out   1  sticky: control code arrived with half a word pending
module glip_uart_rx_ctrl #(
  parameter logic [7:0] ESC = 8'hfe
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_enable,
  input  logic [7:0]                 in_data,
  input  logic                       in_error,
  glip_uart_rx_ctrl_if.master        fifo,
  output logic                       ctrl_strobe,
  output logic [7:0]                 ctrl_code,
  output logic                       err_framing,
  output logic                       err_overflow,
  output logic                       err_protocol
);

  typedef enum logic [1:0] {
    S_HI,
    S_HI_ESC,
    S_LO,
    S_LO_ESC
  } state_t;

  state_t     state;
  logic [7:0] hi_byte;

  // A framing error overrides a byte strobe in the same cycle. This means
  // every byte-driven decision below is qualified with byte_ok.
  logic byte_ok;
  logic is_esc;
  logic word_done;
  logic can_load;

  assign byte_ok = in_enable && !in_error;
  assign is_esc  = (in_data == ESC);

  // A word is completed by a plain low byte in S_LO, or by a literal ESC
  // (ESC ESC) in S_LO_ESC. In both cases in_data is the low byte, because
  // a literal ESC equals the incoming byte.
  always_comb begin
    word_done = 1'b0;
    if (byte_ok) begin
      if (state == S_LO && !is_esc) begin
        word_done = 1'b1;
      end else if (state == S_LO_ESC && is_esc) begin
        word_done = 1'b1;
      end
    end
  end

  // The buffer can take a new word when it is empty, or when the held word
  // is handed off in this same cycle.
  assign can_load = !fifo.out_valid || fifo.out_ready;

  // Escape/assembly FSM together with its registered outputs.
  // A new word load takes priority over the handshake clear, so out_valid
  // stays high when the buffer drains and refills in the same cycle.
  // Control codes go straight to ctrl_strobe and never touch the word
  // buffer. Because a control code and a word completion are exclusive
  // for a given byte, ctrl_strobe never coincides with a word load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_HI;
      hi_byte        <= 8'h00;
      fifo.out_data  <= 16'h0000;
      fifo.out_valid <= 1'b0;
      ctrl_strobe    <= 1'b0;
      ctrl_code      <= 8'h00;
      err_framing    <= 1'b0;
      err_overflow   <= 1'b0;
      err_protocol   <= 1'b0;
    end else begin
      ctrl_strobe <= 1'b0;

      if (word_done && can_load) begin
        fifo.out_data  <= {hi_byte, in_data};
        fifo.out_valid <= 1'b1;
      end else if (fifo.out_valid && fifo.out_ready) begin
        fifo.out_valid <= 1'b0;
      end

      if (word_done && !can_load) begin
        err_overflow <= 1'b1;
      end

      if (in_error) begin
        // Drop any half word and escape state. A word that is already
        // held in the buffer is left alone.
        state       <= S_HI;
        err_framing <= 1'b1;
      end else if (in_enable) begin
        unique case (state)
          S_HI: begin
            if (is_esc) begin
              state <= S_HI_ESC;
            end else begin
              hi_byte <= in_data;
              state   <= S_LO;
            end
          end

          S_HI_ESC: begin
            if (is_esc) begin
              hi_byte <= in_data;
              state   <= S_LO;
            end else begin
              ctrl_strobe <= 1'b1;
              ctrl_code   <= in_data;
              state       <= S_HI;
            end
          end

          S_LO: begin
            if (is_esc) begin
              state <= S_LO_ESC;
            end else begin
              state <= S_HI;
            end
          end

          S_LO_ESC: begin
            if (!is_esc) begin
              // A control code in the middle of a word abandons the
              // pending high byte.
              ctrl_strobe  <= 1'b1;
              ctrl_code    <= in_data;
              err_protocol <= 1'b1;
            end
            state <= S_HI;
          end

          default: begin
            state <= S_HI;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_glip_uart_rx_ctrl.sv
// tb_glip_uart_rx_ctrl
//
// Directed testbench for glip_uart_rx_ctrl. The bench drives inputs and
// samples outputs on the falling clock edge.
module tb_glip_uart_rx_ctrl;

  logic       clk;
  logic       rst;
  logic       in_enable;
  logic [7:0] in_data;
  logic       in_error;
  logic       ctrl_strobe;
  logic [7:0] ctrl_code;
  logic       err_framing;
  logic       err_overflow;
  logic       err_protocol;

  int checks;
  int errors;

  glip_uart_rx_ctrl_if fifo_if ();

  glip_uart_rx_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_enable    (in_enable),
    .in_data      (in_data),
    .in_error     (in_error),
    .fifo         (fifo_if),
    .ctrl_strobe  (ctrl_strobe),
    .ctrl_code    (ctrl_code),
    .err_framing  (err_framing),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one byte strobe for exactly one rising edge. If two calls are
  // back to back, in_enable stays high, which gives consecutive-cycle strobes.
  task automatic applyStimulus(input logic [7:0] b);
    in_enable = 1'b1;
    in_data   = b;
    @(negedge clk);
    in_enable = 1'b0;
  endtask

  task automatic pulseError();
    in_error = 1'b1;
    @(negedge clk);
    in_error = 1'b0;
  endtask

  task automatic drainWord();
    fifo_if.out_ready = 1'b1;
    @(negedge clk);
    fifo_if.out_ready = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    rst               = 1'b1;
    in_enable         = 1'b0;
    in_data           = 8'h00;
    in_error          = 1'b0;
    fifo_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_valid", {15'd0, fifo_if.out_valid}, 16'd0);
    checkOutput("rst_data", fifo_if.out_data, 16'h0000);
    checkOutput("rst_strobe", {15'd0, ctrl_strobe}, 16'd0);
    checkOutput("rst_code", {8'd0, ctrl_code}, 16'd0);
    checkOutput("rst_flags", {13'd0, err_framing, err_overflow, err_protocol}, 16'd0);

    // Basic word: 12 34
    applyStimulus(8'h12);
    checkOutput("w1234_half_valid", {15'd0, fifo_if.out_valid}, 16'd0);
    applyStimulus(8'h34);
    checkOutput("w1234_valid", {15'd0, fifo_if.out_valid}, 16'd1);
    checkOutput("w1234_data", fifo_if.out_data, 16'h1234);
    @(negedge clk);
    checkOutput("w1234_hold", {15'd0, fifo_if.out_valid}, 16'd1);
    drainWord();
    checkOutput("w1234_cleared", {15'd0, fifo_if.out_valid}, 16'd0);

    // Literal ESC as high byte: FE FE 56
    applyStimulus(8'hfe);
    applyStimulus(8'hfe);
    applyStimulus(8'h56);
    checkOutput("wfe56_valid", {15'd0, fifo_if.out_valid}, 16'd1);
    checkOutput("wfe56_data", fifo_if.out_data, 16'hfe56);
    drainWord();

    // Literal ESC as low byte: AB FE FE
    applyStimulus(8'hab);
    applyStimulus(8'hfe);
    applyStimulus(8'hfe);
    checkOutput("wabfe_valid", {15'd0, fifo_if.out_valid}, 16'd1);
    checkOutput("wabfe_data", fifo_if.out_data, 16'habfe);
    drainWord();

    // Control code: FE 01
    applyStimulus(8'hfe);
    applyStimulus(8'h01);
    checkOutput("c01_strobe", {15'd0, ctrl_strobe}, 16'd1);
    checkOutput("c01_code", {8'd0, ctrl_code}, 16'h0001);
    checkOutput("c01_noword", {15'd0, fifo_if.out_valid}, 16'd0);
    checkOutput("c01_noproto", {15'd0, err_protocol}, 16'd0);
    @(negedge clk);
    checkOutput("c01_strobe_drop", {15'd0, ctrl_strobe}, 16'd0);

    // Control code with a half word pending: 11 FE 02, then 33 44
    applyStimulus(8'h11);
    applyStimulus(8'hfe);
    applyStimulus(8'h02);
    checkOutput("c02_strobe", {15'd0, ctrl_strobe}, 16'd1);
    checkOutput("c02_code", {8'd0, ctrl_code}, 16'h0002);
    checkOutput("c02_proto", {15'd0, err_protocol}, 16'd1);
    checkOutput("c02_noword", {15'd0, fifo_if.out_valid}, 16'd0);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    checkOutput("w3344_data", fifo_if.out_data, 16'h3344);
    checkOutput("w3344_valid", {15'd0, fifo_if.out_valid}, 16'd1);
    drainWord();

    // Overflow: 11 22 33 44 with the FIFO stalled
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("ovf_first_data", fifo_if.out_data, 16'h1122);
    checkOutput("ovf_no_err_yet", {15'd0, err_overflow}, 16'd0);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    checkOutput("ovf_kept_data", fifo_if.out_data, 16'h1122);
    checkOutput("ovf_kept_valid", {15'd0, fifo_if.out_valid}, 16'd1);
    checkOutput("ovf_flag", {15'd0, err_overflow}, 16'd1);
    drainWord();

    // Same sequence after reset, with the FIFO draining at the second completion
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst2_flags", {13'd0, err_framing, err_overflow, err_protocol}, 16'd0);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    fifo_if.out_ready = 1'b1;
    applyStimulus(8'h44);
    fifo_if.out_ready = 1'b0;
    checkOutput("swap_data", fifo_if.out_data, 16'h3344);
    checkOutput("swap_valid", {15'd0, fifo_if.out_valid}, 16'd1);
    checkOutput("swap_no_ovf", {15'd0, err_overflow}, 16'd0);
    drainWord();
    checkOutput("swap_cleared", {15'd0, fifo_if.out_valid}, 16'd0);

    // Framing error mid-word: 55, error, 66 77
    applyStimulus(8'h55);
    pulseError();
    checkOutput("fe_flag", {15'd0, err_framing}, 16'd1);
    applyStimulus(8'h66);
    applyStimulus(8'h77);
    checkOutput("fe_data", fifo_if.out_data, 16'h6677);
    checkOutput("fe_valid", {15'd0, fifo_if.out_valid}, 16'd1);

    // Error with a word held, and error winning over a simultaneous byte
    applyStimulus(8'h88);
    in_enable = 1'b1;
    in_data   = 8'h99;
    pulseError();
    in_enable = 1'b0;
    checkOutput("fe_held_valid", {15'd0, fifo_if.out_valid}, 16'd1);
    checkOutput("fe_held_data", fifo_if.out_data, 16'h6677);
    drainWord();
    applyStimulus(8'haa);
    applyStimulus(8'hbb);
    checkOutput("fe_after_data", fifo_if.out_data, 16'haabb);

    // Reset mid-word with a word held: 88, rst, then 99 AA
    applyStimulus(8'h88);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst3_valid", {15'd0, fifo_if.out_valid}, 16'd0);
    checkOutput("rst3_flags", {13'd0, err_framing, err_overflow, err_protocol}, 16'd0);
    applyStimulus(8'h99);
    applyStimulus(8'haa);
    checkOutput("w99aa_data", fifo_if.out_data, 16'h99aa);
    checkOutput("w99aa_valid", {15'd0, fifo_if.out_valid}, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
